// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding reads to
// instruction memory and buffers returned bytes in a 2-entry FIFO for the decoder.
module fetch_unit #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            n_rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_rdata,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            halt,
    input  logic            stall,
    output logic            out_valid,
    output logic [7:0]      out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic [PC_W-1:0] out_pc_inc
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_DRAIN      = 2'd1,
        ST_HALT_DRAIN = 2'd2,
        ST_HALTED     = 2'd3
    } state_t;

    state_t          r_state, w_state_n;
    logic [PC_W-1:0] r_fetch_pc, w_fetch_pc_n;
    logic [PC_W-1:0] r_addr, w_addr_n;
    logic            r_req, w_req_n;
    logic [1:0]      r_count, w_count_n;
    logic [7:0]      r_instr0, r_instr1;
    logic [PC_W-1:0] r_pc0, r_pc1;
    logic            w_ack, w_busy, w_pop, w_push, w_flush, w_issue;
    logic [1:0]      w_wr_idx;

    // w_busy: a request stays outstanding past this edge
    assign w_ack    = imem_ack & r_req;
    assign w_busy   = r_req & ~imem_ack;
    assign w_pop    = (r_count != 2'd0) & ~stall;
    assign w_wr_idx = r_count - {1'b0, w_pop};

    // Next-state, PC, FIFO occupancy and request issue decisions
    always_comb begin
        w_state_n    = r_state;
        w_fetch_pc_n = r_fetch_pc;
        w_push       = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (halt) begin
                    w_flush   = 1'b1;
                    w_state_n = w_busy ? ST_HALT_DRAIN : ST_HALTED;
                end else if (redirect_valid) begin
                    w_flush      = 1'b1;
                    w_fetch_pc_n = redirect_pc;
                    w_state_n    = w_busy ? ST_DRAIN : ST_RUN;
                end else if (w_ack) begin
                    w_push       = 1'b1;
                    w_fetch_pc_n = r_fetch_pc + PC_ONE;
                end else begin
                    w_push = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (halt) begin
                    w_flush   = 1'b1;
                    w_state_n = w_busy ? ST_HALT_DRAIN : ST_HALTED;
                end else if (redirect_valid) begin
                    w_flush      = 1'b1;
                    w_fetch_pc_n = redirect_pc;
                    w_state_n    = w_busy ? ST_DRAIN : ST_RUN;
                end else if (w_ack) begin
                    w_state_n = ST_RUN;
                end else begin
                    w_state_n = ST_DRAIN;
                end
            end
            ST_HALT_DRAIN: begin
                if (w_ack) begin
                    w_state_n = ST_HALTED;
                end else begin
                    w_state_n = ST_HALT_DRAIN;
                end
            end
            ST_HALTED: begin
                if (redirect_valid) begin
                    w_fetch_pc_n = redirect_pc;
                    w_state_n    = ST_RUN;
                end else begin
                    w_state_n = ST_HALTED;
                end
            end
            default: begin
                w_state_n = ST_RUN;
            end
        endcase

        if (w_flush) begin
            w_count_n = 2'd0;
        end else begin
            w_count_n = r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
        // A new request is decided from the occupancy seen next cycle
        w_issue  = (w_state_n == ST_RUN) & ~w_busy & (w_count_n < 2'd2);
        w_req_n  = w_busy | w_issue;
        w_addr_n = w_issue ? w_fetch_pc_n : r_addr;
    end

    // State, PC, request and FIFO registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= ST_RUN;
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
            r_req      <= 1'b0;
            r_count    <= 2'd0;
            r_instr0   <= 8'd0;
            r_instr1   <= 8'd0;
            r_pc0      <= '0;
            r_pc1      <= '0;
        end else begin
            r_state    <= w_state_n;
            r_fetch_pc <= w_fetch_pc_n;
            r_addr     <= w_addr_n;
            r_req      <= w_req_n;
            r_count    <= w_count_n;
            if (!w_flush) begin
                if (w_pop) begin
                    r_instr0 <= r_instr1;
                    r_pc0    <= r_pc1;
                end else begin
                    r_instr0 <= r_instr0;
                end
                if (w_push && (w_wr_idx == 2'd0)) begin
                    r_instr0 <= imem_rdata;
                    r_pc0    <= r_addr;
                end else if (w_push) begin
                    r_instr1 <= imem_rdata;
                    r_pc1    <= r_addr;
                end else begin
                    r_instr1 <= r_instr1;
                end
            end else begin
                r_instr0 <= r_instr0;
            end
        end
    end

    assign imem_req   = r_req;
    assign imem_addr  = r_addr;
    assign out_valid  = (r_count != 2'd0);
    assign out_instr  = r_instr0;
    assign out_pc     = r_pc0;
    assign out_pc_inc = r_pc0 + PC_ONE;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand sequences for
// redirect/halt/wrap/reset corners, and a randomized run against a queue model.
module tb_fetch_unit;

    logic       clk;
    logic       n_rst;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic       halt;
    logic       stall;
    logic       out_valid;
    logic [7:0] out_instr;
    logic [7:0] out_pc;
    logic [7:0] out_pc_inc;

    fetch_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .n_rst(n_rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .stall(stall),
        .out_valid(out_valid), .out_instr(out_instr),
        .out_pc(out_pc), .out_pc_inc(out_pc_inc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct { logic [7:0] instr; logic [7:0] pc; } ent_t;
    ent_t       q[$];
    logic [7:0] m_fpc;
    logic [7:0] m_addr;
    bit         m_out;
    bit         m_stale;
    bit         m_to_halt;
    bit         m_halted;

    int lat  = 0;
    int wcnt = 0;
    bit spur = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_fpc = 8'h00; m_addr = 8'h00;
        m_out = 1'b0; m_stale = 1'b0; m_to_halt = 1'b0; m_halted = 1'b0;
    endtask

    // Transaction-level reference: queue of fetched {instr,pc} plus stale/halt flags
    task automatic model_step();
        bit ack_eff, busy, pop;
        ack_eff = imem_ack && m_out;
        busy    = m_out && !imem_ack;
        pop     = (q.size() != 0) && !stall;
        if (m_halted) begin
            if (redirect_valid) begin
                m_fpc = redirect_pc;
                m_halted = 1'b0;
            end
        end else if (halt && !m_to_halt) begin
            q.delete();
            m_stale = busy; m_to_halt = busy; m_halted = !busy;
        end else if (redirect_valid && !m_to_halt) begin
            q.delete();
            m_fpc = redirect_pc;
            m_stale = busy;
        end else begin
            if (pop) void'(q.pop_front());
            if (ack_eff) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                    if (m_to_halt) begin
                        m_to_halt = 1'b0;
                        m_halted  = 1'b1;
                    end
                end else begin
                    q.push_back(ent_t'{imem_rdata, m_addr});
                    m_fpc = m_fpc + 8'd1;
                end
            end
        end
        m_out = busy;
        if (!m_halted && !m_stale && !m_out && q.size() < 2) begin
            m_out  = 1'b1;
            m_addr = m_fpc;
        end
    endtask

    // Memory: mem[a] = a ^ 5A, acking after 'lat' extra cycles of request
    task automatic drive_mem();
        if (imem_req) begin
            if (wcnt >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = imem_addr ^ 8'h5A;
                wcnt = 0;
            end else begin
                imem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            wcnt       = 0;
            imem_ack   = spur && ($urandom_range(0, 3) == 0);
            imem_rdata = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic cycle();
        logic [7:0] inc;
        chk("req", imem_req, m_out);
        if (m_out) chk("addr", imem_addr, m_addr);
        chk("valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            inc = q[0].pc + 8'd1;
            chk("out_pc", out_pc, q[0].pc);
            chk("out_instr", out_instr, q[0].instr);
            chk("out_pc_inc", out_pc_inc, inc);
        end
        drive_mem();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        imem_ack = 1'b0; imem_rdata = 8'h00;
        redirect_valid = 1'b0; redirect_pc = 8'h00;
        halt = 1'b0; stall = 1'b0; spur = 1'b0;
        wcnt = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 8'h00);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_instr", out_instr, 8'h00);
        chk("rst_pc", out_pc, 8'h00);
        chk("rst_pc_inc", out_pc_inc, 8'h01);
        n_rst = 1'b1;
    endtask

    typedef struct {
        logic       stall;
        logic       e_req;
        logic [7:0] e_addr;
        logic       e_valid;
        logic [7:0] e_pc;
    } vec_t;
    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 1'b1, 8'h01, 1'b1, 8'h00};
        tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00};
        tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00};
        tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
        tbl[8]  = '{1'b0, 1'b1, 8'h02, 1'b1, 8'h01};
        tbl[9]  = '{1'b0, 1'b1, 8'h03, 1'b1, 8'h02};
        tbl[10] = '{1'b0, 1'b1, 8'h04, 1'b1, 8'h03};

        // Zero-wait streaming with a 5-cycle stall window
        do_reset();
        lat = 0;
        for (int i = 0; i < 11; i++) begin
            logic [7:0] ei;
            ei = tbl[i].e_pc ^ 8'h5A;
            chk("tbl_req", imem_req, tbl[i].e_req);
            if (tbl[i].e_req) chk("tbl_addr", imem_addr, tbl[i].e_addr);
            chk("tbl_valid", out_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) begin
                chk("tbl_pc", out_pc, tbl[i].e_pc);
                chk("tbl_instr", out_instr, ei);
            end
            stall = tbl[i].stall;
            cycle();
        end
        stall = 1'b0;
        repeat (8) cycle();

        // Redirect to 0x40 while a 3-cycle fetch of 0x05 is outstanding
        do_reset();
        lat = 2;
        for (int i = 0; i < 100 && !(imem_req && imem_addr == 8'h05); i++) cycle();
        chk("seen_req_05", imem_req && imem_addr == 8'h05, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 8'h40;
        cycle();
        redirect_valid = 1'b0;
        for (int i = 0; i < 10 && imem_req && imem_addr == 8'h05; i++) begin
            chk("drain_valid", out_valid, 1'b0);
            cycle();
        end
        chk("req_after_drain", imem_req, 1'b1);
        chk("addr_after_drain", imem_addr, 8'h40);
        for (int i = 0; i < 20 && !out_valid; i++) cycle();
        chk("first_pc_40", out_pc, 8'h40);
        chk("first_instr_40", out_instr, 8'h1A);
        repeat (4) cycle();

        // Halt with a request outstanding, then resume at 0x10
        do_reset();
        lat = 2;
        for (int i = 0; i < 100 && !(imem_req && wcnt == 0 && imem_addr == 8'h03); i++) cycle();
        chk("seen_req_03", imem_req && imem_addr == 8'h03, 1'b1);
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        for (int i = 0; i < 10 && imem_req; i++) begin
            chk("hdrain_valid", out_valid, 1'b0);
            cycle();
        end
        for (int i = 0; i < 5; i++) begin
            chk("halted_req", imem_req, 1'b0);
            chk("halted_valid", out_valid, 1'b0);
            cycle();
        end
        redirect_valid = 1'b1; redirect_pc = 8'h10;
        cycle();
        redirect_valid = 1'b0;
        for (int i = 0; i < 30 && !out_valid; i++) cycle();
        chk("resume_pc_10", out_pc, 8'h10);
        repeat (4) cycle();

        // Halt and redirect together: halt wins
        do_reset();
        lat = 0;
        repeat (5) cycle();
        halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h77;
        cycle();
        halt = 1'b0; redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("hr_req", imem_req, 1'b0);
            chk("hr_valid", out_valid, 1'b0);
            cycle();
        end
        redirect_valid = 1'b1; redirect_pc = 8'h20;
        cycle();
        redirect_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) cycle();
        chk("hr_resume_pc", out_pc, 8'h20);

        // PC wrap through 0xFF
        do_reset();
        lat = 0;
        redirect_valid = 1'b1; redirect_pc = 8'hFD;
        cycle();
        redirect_valid = 1'b0;
        for (int i = 0; i < 20 && !(out_valid && out_pc == 8'hFF); i++) cycle();
        chk("wrap_pc_ff", out_pc, 8'hFF);
        chk("wrap_inc", out_pc_inc, 8'h00);
        cycle();
        chk("wrap_valid", out_valid, 1'b1);
        chk("wrap_pc_00", out_pc, 8'h00);

        // Asynchronous reset in the middle of a slow request
        lat = 3;
        for (int i = 0; i < 20 && !(imem_req && wcnt == 1); i++) cycle();
        chk("mid_req_high", imem_req, 1'b1);
        #2 n_rst = 1'b0;
        #1;
        chk("async_req", imem_req, 1'b0);
        chk("async_valid", out_valid, 1'b0);
        chk("async_pc", out_pc, 8'h00);
        chk("async_inc", out_pc_inc, 8'h01);
        chk("async_instr", out_instr, 8'h00);
        chk("async_addr", imem_addr, 8'h00);
        imem_ack = 1'b0;
        model_reset();
        wcnt = 0;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (6) cycle();

        // Randomized run against the model
        do_reset();
        spur = 1'b1;
        for (int s = 0; s < 20; s++) begin
            lat = $urandom_range(0, 3);
            for (int c = 0; c < 100; c++) begin
                stall          = ($urandom_range(0, 9) < 3);
                redirect_valid = ($urandom_range(0, 99) < 4);
                halt           = ($urandom_range(0, 99) < 2);
                redirect_pc    = 8'($urandom_range(0, 255));
                cycle();
            end
        end
        redirect_valid = 1'b0; halt = 1'b0; stall = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
